// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage 16-bit CPU: opcodes, hazard FSM states
// and next-PC select encodings.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'h0,
        OP_SUB   = 4'h1,
        OP_AND   = 4'h2,
        OP_OR    = 4'h3,
        OP_XOR   = 4'h4,
        OP_SLL   = 4'h5,
        OP_SRL   = 4'h6,
        OP_ADDI  = 4'h7,
        OP_LW    = 4'h8,
        OP_SW    = 4'h9,
        OP_LB    = 4'hA,
        OP_BEQ   = 4'hB,
        OP_BNE   = 4'hC,
        OP_CALL  = 4'hD,
        OP_RET   = 4'hE,
        OP_FLUSH = 4'hF
    } opcode_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        RET_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } hazard_state_t;

    localparam logic [1:0] PCSEL_INC    = 2'b00;
    localparam logic [1:0] PCSEL_BRANCH = 2'b01;
    localparam logic [1:0] PCSEL_CALL   = 2'b10;
    localparam logic [1:0] PCSEL_RET    = 2'b11;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: a load in EX whose destination is
// read by the instruction currently in ID.
module load_use_detect
    import cpu_pkg::*;
(
    input  logic       ex_mem_read,
    input  logic       ex_reg_write,
    input  logic [3:0] ex_dst,
    input  logic [3:0] id_rs,
    input  logic [3:0] id_rt,
    input  logic       id_reg0_read,
    input  logic       id_reg1_read,
    output logic       hazard
);

    // R0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign hazard = ex_mem_read & ex_reg_write & (ex_dst != 4'd0) &
                    ((id_reg0_read & (id_rs == ex_dst)) |
                     (id_reg1_read & (id_rt == ex_dst)));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch/CALL/RET redirects
// and halt drain. Optional stall counter enabled by HAZARD_CTRL_STATS_EN.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] id_opcode,
    input  logic [3:0] id_rs,
    input  logic [3:0] id_rt,
    input  logic       id_reg0_read,
    input  logic       id_reg1_read,
    input  logic       ex_mem_read,
    input  logic [3:0] ex_dst,
    input  logic       ex_reg_write,
    input  logic       ex_branch_taken,
    input  logic       wb_ret,
    output logic       pc_write,
    output logic       if_id_write,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic [1:0] pc_sel,
    output logic       halted
`ifdef HAZARD_CTRL_STATS_EN
    ,
    output logic [15:0] stall_cycles
`endif
);

    hazard_state_t state_r, next_state_s;
    logic [1:0]    cnt_r, next_cnt_s;
    logic          halted_r;
    logic          hazard_s;
    logic          pc_write_s, if_id_write_s, if_id_flush_s, id_ex_flush_s;
    logic [1:0]    pc_sel_s;

    load_use_detect u_load_use_detect (
        .ex_mem_read  (ex_mem_read),
        .ex_reg_write (ex_reg_write),
        .ex_dst       (ex_dst),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_reg0_read (id_reg0_read),
        .id_reg1_read (id_reg1_read),
        .hazard       (hazard_s)
    );

    // Next-state and same-cycle control decode; reset forces the RUN defaults.
    always_comb begin
        next_state_s  = state_r;
        next_cnt_s    = cnt_r;
        pc_write_s    = 1'b1;
        if_id_write_s = 1'b1;
        if_id_flush_s = 1'b0;
        id_ex_flush_s = 1'b0;
        pc_sel_s      = PCSEL_INC;
        if (rst) begin
            next_state_s = RUN;
            next_cnt_s   = 2'd0;
        end else begin
            case (state_r)
                RUN: begin
                    if (ex_branch_taken) begin
                        pc_sel_s      = PCSEL_BRANCH;
                        if_id_flush_s = 1'b1;
                        id_ex_flush_s = 1'b1;
                    end else if (hazard_s) begin
                        pc_write_s    = 1'b0;
                        if_id_write_s = 1'b0;
                        id_ex_flush_s = 1'b1;
                    end else if (id_opcode == OP_CALL) begin
                        pc_sel_s      = PCSEL_CALL;
                        if_id_flush_s = 1'b1;
                    end else if (id_opcode == OP_RET) begin
                        pc_write_s    = 1'b0;
                        if_id_flush_s = 1'b1;
                        next_state_s  = RET_WAIT;
                    end else if ((id_opcode == OP_FLUSH) && id_reg0_read) begin
                        // A bubble also carries 4'hF; only a real HLT reads port 0.
                        pc_write_s    = 1'b0;
                        if_id_flush_s = 1'b1;
                        next_cnt_s    = 2'(DRAIN_CYCLES - 1);
                        next_state_s  = DRAIN;
                    end else begin
                        pc_sel_s = PCSEL_INC;
                    end
                end
                RET_WAIT: begin
                    if_id_flush_s = 1'b1;
                    if (wb_ret) begin
                        pc_sel_s     = PCSEL_RET;
                        next_state_s = RUN;
                    end else begin
                        pc_write_s = 1'b0;
                    end
                end
                DRAIN: begin
                    pc_write_s    = 1'b0;
                    if_id_write_s = 1'b0;
                    if_id_flush_s = 1'b1;
                    if (cnt_r == 2'd0) begin
                        next_state_s = HALTED;
                    end else begin
                        next_cnt_s = cnt_r - 2'd1;
                    end
                end
                HALTED: begin
                    pc_write_s    = 1'b0;
                    if_id_write_s = 1'b0;
                end
                default: begin
                    next_state_s = RUN;
                    next_cnt_s   = 2'd0;
                end
            endcase
        end
    end

    // FSM state, drain counter and halted flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= RUN;
            cnt_r    <= 2'd0;
            halted_r <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            cnt_r    <= next_cnt_s;
            halted_r <= (next_state_s == HALTED);
        end
    end

    assign pc_write    = pc_write_s;
    assign if_id_write = if_id_write_s;
    assign if_id_flush = if_id_flush_s;
    assign id_ex_flush = id_ex_flush_s;
    assign pc_sel      = pc_sel_s;
    assign halted      = halted_r;

`ifdef HAZARD_CTRL_STATS_EN
    logic [15:0] stall_cnt_r;

    // Count every non-halted cycle in which the PC is held; wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 16'd0;
        end else if (!pc_write_s && (state_r != HALTED)) begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cycles = stall_cnt_r;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (default build).
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] id_opcode, id_rs, id_rt, ex_dst;
    logic       id_reg0_read, id_reg1_read, ex_mem_read, ex_reg_write;
    logic       ex_branch_taken, wb_ret;
    logic       pc_write, if_id_write, if_id_flush, id_ex_flush, halted;
    logic [1:0] pc_sel;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.DRAIN_CYCLES(3)) dut (
        .clk(clk), .rst(rst),
        .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .id_reg0_read(id_reg0_read), .id_reg1_read(id_reg1_read),
        .ex_mem_read(ex_mem_read), .ex_dst(ex_dst), .ex_reg_write(ex_reg_write),
        .ex_branch_taken(ex_branch_taken), .wb_ret(wb_ret),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .pc_sel(pc_sel), .halted(halted)
    );

    // {pc_write, if_id_write, if_id_flush, id_ex_flush, pc_sel, halted}
    wire [6:0] outs = {pc_write, if_id_write, if_id_flush, id_ex_flush, pc_sel, halted};
    localparam logic [6:0] V_NORM   = 7'b1100_00_0;
    localparam logic [6:0] V_LU     = 7'b0001_00_0;
    localparam logic [6:0] V_BR     = 7'b1111_01_0;
    localparam logic [6:0] V_CALL   = 7'b1110_10_0;
    localparam logic [6:0] V_HOLD   = 7'b0110_00_0;
    localparam logic [6:0] V_RETWB  = 7'b1110_11_0;
    localparam logic [6:0] V_DRAIN  = 7'b0010_00_0;
    localparam logic [6:0] V_HALTED = 7'b0000_00_1;

    task automatic idle();
        id_opcode = 4'h0; id_rs = 4'd1; id_rt = 4'd2;
        id_reg0_read = 1'b1; id_reg1_read = 1'b1;
        ex_mem_read = 1'b0; ex_dst = 4'd0; ex_reg_write = 1'b0;
        ex_branch_taken = 1'b0; wb_ret = 1'b0;
    endtask

    task automatic bubble_in_id();
        id_opcode = 4'hF; id_reg0_read = 1'b0; id_reg1_read = 1'b0;
    endtask

    task automatic load_r3_in_ex();
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dst = 4'd3;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle(); id_opcode = 4'hE;
        @(negedge clk); total++;
        if (outs !== V_NORM) begin bad++; $display("FAIL reset_during got=%b exp=%b", outs, V_NORM); end
        tick(); tick(); rst = 1'b0; idle();
        @(negedge clk); total++;
        if (outs !== V_NORM) begin bad++; $display("FAIL reset_after got=%b exp=%b", outs, V_NORM); end
        tick();
    endtask

    task automatic test_load_use();
        idle(); load_r3_in_ex(); id_rs = 4'd3;
        @(negedge clk); total++;
        if (outs !== V_LU) begin bad++; $display("FAIL lu_rs got=%b exp=%b", outs, V_LU); end
        tick(); ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_dst = 4'd0;
        @(negedge clk); total++;
        if (outs !== V_NORM) begin bad++; $display("FAIL lu_release got=%b exp=%b", outs, V_NORM); end
        tick(); idle(); load_r3_in_ex(); id_rt = 4'd3;
        @(negedge clk); total++;
        if (outs !== V_LU) begin bad++; $display("FAIL lu_rt got=%b exp=%b", outs, V_LU); end
        tick(); idle(); load_r3_in_ex(); ex_dst = 4'd0; id_rs = 4'd0;
        @(negedge clk); total++;
        if (outs !== V_NORM) begin bad++; $display("FAIL lu_r0 got=%b exp=%b", outs, V_NORM); end
        tick(); idle(); load_r3_in_ex(); id_rs = 4'd3; id_reg0_read = 1'b0;
        @(negedge clk); total++;
        if (outs !== V_NORM) begin bad++; $display("FAIL lu_noread got=%b exp=%b", outs, V_NORM); end
        tick(); idle(); load_r3_in_ex(); id_rs = 4'd3; ex_reg_write = 1'b0;
        @(negedge clk); total++;
        if (outs !== V_NORM) begin bad++; $display("FAIL lu_nowrite got=%b exp=%b", outs, V_NORM); end
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2; i++) begin
            idle(); load_r3_in_ex(); id_rs = 4'd3;
            @(negedge clk); total++;
            if (outs !== V_LU) begin bad++; $display("FAIL b2b_stall%0d got=%b exp=%b", i, outs, V_LU); end
            tick(); idle(); id_rs = 4'd3;
            @(negedge clk); total++;
            if (outs !== V_NORM) begin bad++; $display("FAIL b2b_go%0d got=%b exp=%b", i, outs, V_NORM); end
            tick();
        end
    endtask

    task automatic test_branch_priority();
        idle(); load_r3_in_ex(); id_rs = 4'd3; id_opcode = 4'hE; ex_branch_taken = 1'b1;
        @(negedge clk); total++;
        if (outs !== V_BR) begin bad++; $display("FAIL br_over_ret got=%b exp=%b", outs, V_BR); end
        tick(); idle();
        @(negedge clk); total++;
        if (outs !== V_NORM) begin bad++; $display("FAIL br_stay_run got=%b exp=%b", outs, V_NORM); end
        tick(); idle(); id_opcode = 4'hF; ex_branch_taken = 1'b1;
        @(negedge clk); total++;
        if (outs !== V_BR) begin bad++; $display("FAIL br_over_hlt got=%b exp=%b", outs, V_BR); end
        tick(); idle();
        @(negedge clk); total++;
        if (outs !== V_NORM) begin bad++; $display("FAIL br_no_drain got=%b exp=%b", outs, V_NORM); end
        tick();
    endtask

    task automatic test_call();
        idle(); id_opcode = 4'hD;
        @(negedge clk); total++;
        if (outs !== V_CALL) begin bad++; $display("FAIL call got=%b exp=%b", outs, V_CALL); end
        tick(); idle();
        @(negedge clk); total++;
        if (outs !== V_NORM) begin bad++; $display("FAIL call_after got=%b exp=%b", outs, V_NORM); end
        tick();
    endtask

    task automatic test_ret();
        idle(); id_opcode = 4'hE; id_reg0_read = 1'b0;
        @(negedge clk); total++;
        if (outs !== V_HOLD) begin bad++; $display("FAIL ret_decode got=%b exp=%b", outs, V_HOLD); end
        tick(); bubble_in_id();
        @(negedge clk); total++;
        if (outs !== V_HOLD) begin bad++; $display("FAIL ret_wait1 got=%b exp=%b", outs, V_HOLD); end
        tick(); ex_branch_taken = 1'b1;
        @(negedge clk); total++;
        if (outs !== V_HOLD) begin bad++; $display("FAIL ret_wait_br got=%b exp=%b", outs, V_HOLD); end
        tick(); ex_branch_taken = 1'b0; wb_ret = 1'b1;
        @(negedge clk); total++;
        if (outs !== V_RETWB) begin bad++; $display("FAIL ret_wb got=%b exp=%b", outs, V_RETWB); end
        tick(); idle();
        @(negedge clk); total++;
        if (outs !== V_NORM) begin bad++; $display("FAIL ret_back_run got=%b exp=%b", outs, V_NORM); end
        tick();
    endtask

    task automatic test_reset_in_ret_wait();
        idle(); id_opcode = 4'hE;
        tick(); bubble_in_id();
        @(negedge clk); total++;
        if (outs !== V_HOLD) begin bad++; $display("FAIL rstret_wait got=%b exp=%b", outs, V_HOLD); end
        tick(); rst = 1'b1;
        @(negedge clk); total++;
        if (outs !== V_NORM) begin bad++; $display("FAIL rstret_during got=%b exp=%b", outs, V_NORM); end
        tick(); rst = 1'b0; idle(); wb_ret = 1'b1;
        @(negedge clk); total++;
        if (outs !== V_NORM) begin bad++; $display("FAIL rstret_wb_ignored got=%b exp=%b", outs, V_NORM); end
        tick(); wb_ret = 1'b0;
    endtask

    task automatic test_halt();
        idle(); bubble_in_id();
        @(negedge clk); total++;
        if (outs !== V_NORM) begin bad++; $display("FAIL hlt_bubble got=%b exp=%b", outs, V_NORM); end
        tick(); idle(); id_opcode = 4'hF;
        @(negedge clk); total++;
        if (outs !== V_HOLD) begin bad++; $display("FAIL hlt_decode got=%b exp=%b", outs, V_HOLD); end
        tick(); bubble_in_id();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); total++;
            if (outs !== V_DRAIN) begin bad++; $display("FAIL hlt_drain%0d got=%b exp=%b", i, outs, V_DRAIN); end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            ex_branch_taken = (i == 1); wb_ret = (i == 2);
            id_opcode = (i == 3) ? 4'hE : 4'hF;
            @(negedge clk); total++;
            if (outs !== V_HALTED) begin bad++; $display("FAIL hlt_halted%0d got=%b exp=%b", i, outs, V_HALTED); end
            tick();
        end
        idle(); rst = 1'b1;
        @(negedge clk); total++;
        if (outs[6:1] !== V_NORM[6:1]) begin bad++; $display("FAIL hlt_rst_during got=%b exp=%b", outs[6:1], V_NORM[6:1]); end
        tick(); rst = 1'b0;
        @(negedge clk); total++;
        if (outs !== V_NORM) begin bad++; $display("FAIL hlt_rst_after got=%b exp=%b", outs, V_NORM); end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_load_use();
        test_back_to_back();
        test_branch_priority();
        test_call();
        test_ret();
        test_reset_in_ret_wait();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
